// File: rtl/zynq_axi_arb_pkg.sv
// zynq_axi_arb_pkg: FSM state encodings and fixed AXI3 attribute values
// shared by the two-requester AXI master arbiter.
package zynq_axi_arb_pkg;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
    localparam logic [1:0] AXI_LOCK  = 2'b00;
    localparam logic [3:0] AXI_CACHE = 4'b0011;
    localparam logic [2:0] AXI_PROT  = 3'b000;
    localparam logic [3:0] AXI_QOS   = 4'b0000;
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction
endpackage

// File: rtl/zynq_axi_rr_arb2.sv
// zynq_axi_rr_arb2: two-input round-robin arbiter; the registered pointer
// favours the requester not granted last and only moves when a grant is taken.
module zynq_axi_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic       gnt_o
);
    logic ptr_q, ptr_d;
    assign gnt_o = &req_i ? ptr_q : req_i[1];
    assign ptr_d = (en_i && |req_i) ? ~gnt_o : ptr_q;
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) ptr_q <= 1'b0;
        else         ptr_q <= ptr_d;
endmodule

// File: rtl/zynq_axi_m_arbiter.sv
// zynq_axi_m_arbiter: arbitrates two AXI3 requesters onto one master port with
// independent write/read FSMs. ZYNQ_AXI_ARB_PERF_CNT_EN enables burst counters.
module zynq_axi_m_arbiter
    import zynq_axi_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    parameter int ID_W   = 6
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [1:0][ADDR_W-1:0]       s_awaddr,
    input  logic [1:0][LEN_W-1:0]        s_awlen,
    input  logic [1:0][2:0]              s_awsize,
    input  logic [1:0][1:0]              s_awburst,
    input  logic [1:0]                   s_awvalid,
    output logic [1:0]                   s_awready,
    input  logic [1:0][DATA_W-1:0]       s_wdata,
    input  logic [1:0][DATA_W/8-1:0]     s_wstrb,
    input  logic [1:0]                   s_wlast,
    input  logic [1:0]                   s_wvalid,
    output logic [1:0]                   s_wready,
    output logic [1:0][1:0]              s_bresp,
    output logic [1:0]                   s_bvalid,
    input  logic [1:0]                   s_bready,
    input  logic [1:0][ADDR_W-1:0]       s_araddr,
    input  logic [1:0][LEN_W-1:0]        s_arlen,
    input  logic [1:0][2:0]              s_arsize,
    input  logic [1:0][1:0]              s_arburst,
    input  logic [1:0]                   s_arvalid,
    output logic [1:0]                   s_arready,
    output logic [1:0][DATA_W-1:0]       s_rdata,
    output logic [1:0][1:0]              s_rresp,
    output logic [1:0]                   s_rlast,
    output logic [1:0]                   s_rvalid,
    input  logic [1:0]                   s_rready,
    output logic [ID_W-1:0]              m00_axi_awid,
    output logic [ADDR_W-1:0]            m00_axi_awaddr,
    output logic [LEN_W-1:0]             m00_axi_awlen,
    output logic [2:0]                   m00_axi_awsize,
    output logic [1:0]                   m00_axi_awburst,
    output logic [1:0]                   m00_axi_awlock,
    output logic [3:0]                   m00_axi_awcache,
    output logic [2:0]                   m00_axi_awprot,
    output logic [3:0]                   m00_axi_awqos,
    output logic                         m00_axi_awvalid,
    input  logic                         m00_axi_awready,
    output logic [ID_W-1:0]              m00_axi_wid,
    output logic [DATA_W-1:0]            m00_axi_wdata,
    output logic [DATA_W/8-1:0]          m00_axi_wstrb,
    output logic                         m00_axi_wlast,
    output logic                         m00_axi_wvalid,
    input  logic                         m00_axi_wready,
    input  logic [ID_W-1:0]              m00_axi_bid,
    input  logic [1:0]                   m00_axi_bresp,
    input  logic                         m00_axi_bvalid,
    output logic                         m00_axi_bready,
    output logic [ID_W-1:0]              m00_axi_arid,
    output logic [ADDR_W-1:0]            m00_axi_araddr,
    output logic [LEN_W-1:0]             m00_axi_arlen,
    output logic [2:0]                   m00_axi_arsize,
    output logic [1:0]                   m00_axi_arburst,
    output logic [1:0]                   m00_axi_arlock,
    output logic [3:0]                   m00_axi_arcache,
    output logic [2:0]                   m00_axi_arprot,
    output logic [3:0]                   m00_axi_arqos,
    output logic                         m00_axi_arvalid,
    input  logic                         m00_axi_arready,
    input  logic [ID_W-1:0]              m00_axi_rid,
    input  logic [DATA_W-1:0]            m00_axi_rdata,
    input  logic [1:0]                   m00_axi_rresp,
    input  logic                         m00_axi_rlast,
    input  logic                         m00_axi_rvalid,
    output logic                         m00_axi_rready,
    output logic [1:0][31:0]             grant_cnt_o
);
    wr_state_e  w_q;
    rd_state_e  r_q;
    logic       gw_q, gw_d, gr_q, gr_d;
    logic [1:0] sel_w, sel_r, b_sel, r_sel;
    logic       unused_ids;
    assign unused_ids = ^{m00_axi_bid, m00_axi_rid};

    zynq_axi_rr_arb2 u_aw_arb (.clk_i(aclk), .rst_ni(aresetn), .req_i(s_awvalid),
                               .en_i(w_q == W_IDLE), .gnt_o(gw_d));
    zynq_axi_rr_arb2 u_ar_arb (.clk_i(aclk), .rst_ni(aresetn), .req_i(s_arvalid),
                               .en_i(r_q == R_IDLE), .gnt_o(gr_d));

    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            w_q  <= W_IDLE;
            gw_q <= 1'b0;
        end else begin
            case (w_q)
                W_IDLE:  if (|s_awvalid) begin
                             w_q  <= W_ADDR;
                             gw_q <= gw_d;
                         end
                W_ADDR:  if (m00_axi_awvalid && m00_axi_awready) w_q <= W_DATA;
                W_DATA:  if (m00_axi_wvalid && m00_axi_wready && m00_axi_wlast) w_q <= W_RESP;
                W_RESP:  if (m00_axi_bvalid && m00_axi_bready) w_q <= W_IDLE;
                default: w_q <= W_IDLE;
            endcase
        end

    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            r_q  <= R_IDLE;
            gr_q <= 1'b0;
        end else begin
            case (r_q)
                R_IDLE:  if (|s_arvalid) begin
                             r_q  <= R_ADDR;
                             gr_q <= gr_d;
                         end
                R_ADDR:  if (m00_axi_arvalid && m00_axi_arready) r_q <= R_DATA;
                R_DATA:  if (m00_axi_rvalid && m00_axi_rready && m00_axi_rlast) r_q <= R_IDLE;
                default: r_q <= R_IDLE;
            endcase
        end

    assign sel_w = onehot2(gw_q);
    assign sel_r = onehot2(gr_q);

    assign m00_axi_awid    = {{(ID_W-1){1'b0}}, gw_q};
    assign m00_axi_awaddr  = s_awaddr[gw_q];
    assign m00_axi_awlen   = s_awlen[gw_q];
    assign m00_axi_awsize  = s_awsize[gw_q];
    assign m00_axi_awburst = s_awburst[gw_q];
    assign m00_axi_awlock  = AXI_LOCK;
    assign m00_axi_awcache = AXI_CACHE;
    assign m00_axi_awprot  = AXI_PROT;
    assign m00_axi_awqos   = AXI_QOS;
    assign m00_axi_awvalid = (w_q == W_ADDR) && s_awvalid[gw_q];
    assign s_awready       = (w_q == W_ADDR && m00_axi_awready) ? sel_w : 2'b00;

    // W beats are held off until the FSM reaches W_DATA for the granted requester
    assign m00_axi_wid    = {{(ID_W-1){1'b0}}, gw_q};
    assign m00_axi_wdata  = s_wdata[gw_q];
    assign m00_axi_wstrb  = s_wstrb[gw_q];
    assign m00_axi_wlast  = s_wlast[gw_q];
    assign m00_axi_wvalid = (w_q == W_DATA) && s_wvalid[gw_q];
    assign s_wready       = (w_q == W_DATA && m00_axi_wready) ? sel_w : 2'b00;

    assign b_sel          = (w_q == W_RESP) ? sel_w : 2'b00;
    assign s_bvalid       = m00_axi_bvalid ? b_sel : 2'b00;
    assign m00_axi_bready = (w_q == W_RESP) && s_bready[gw_q];

    assign m00_axi_arid    = {{(ID_W-1){1'b0}}, gr_q};
    assign m00_axi_araddr  = s_araddr[gr_q];
    assign m00_axi_arlen   = s_arlen[gr_q];
    assign m00_axi_arsize  = s_arsize[gr_q];
    assign m00_axi_arburst = s_arburst[gr_q];
    assign m00_axi_arlock  = AXI_LOCK;
    assign m00_axi_arcache = AXI_CACHE;
    assign m00_axi_arprot  = AXI_PROT;
    assign m00_axi_arqos   = AXI_QOS;
    assign m00_axi_arvalid = (r_q == R_ADDR) && s_arvalid[gr_q];
    assign s_arready       = (r_q == R_ADDR && m00_axi_arready) ? sel_r : 2'b00;

    assign r_sel          = (r_q == R_DATA) ? sel_r : 2'b00;
    assign s_rvalid       = m00_axi_rvalid ? r_sel : 2'b00;
    assign m00_axi_rready = (r_q == R_DATA) && s_rready[gr_q];

    for (genvar i = 0; i < 2; i++) begin : g_route
        assign s_bresp[i] = b_sel[i] ? m00_axi_bresp : 2'b00;
        assign s_rdata[i] = r_sel[i] ? m00_axi_rdata : '0;
        assign s_rresp[i] = r_sel[i] ? m00_axi_rresp : 2'b00;
        assign s_rlast[i] = r_sel[i] && m00_axi_rlast;
    end

`ifdef ZYNQ_AXI_ARB_PERF_CNT_EN
    logic [1:0][31:0] cnt_q, cnt_d;
    logic [1:0]       b_done, r_done;
    assign b_done = s_bvalid & s_bready;
    assign r_done = s_rvalid & s_rready & s_rlast;
    for (genvar i = 0; i < 2; i++) begin : g_cnt
        assign cnt_d[i] = cnt_q[i] + 32'(b_done[i]) + 32'(r_done[i]);
    end
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    assign grant_cnt_o = cnt_q;
`else
    assign grant_cnt_o = '0;
`endif
endmodule

// File: tb/tb_zynq_axi_m_arbiter.sv
// tb_zynq_axi_m_arbiter: directed bench driving both requesters and the memory
// side by hand; counter expectations follow ZYNQ_AXI_ARB_PERF_CNT_EN.
module tb_zynq_axi_m_arbiter;
    localparam int AW = 32, DW = 32, LW = 4, IW = 6;
`ifdef ZYNQ_AXI_ARB_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    logic aclk = 1'b0, aresetn = 1'b0;
    logic [1:0][AW-1:0] s_awaddr, s_araddr;
    logic [1:0][LW-1:0] s_awlen, s_arlen;
    logic [1:0][2:0] s_awsize, s_arsize;
    logic [1:0][1:0] s_awburst, s_arburst, s_bresp, s_rresp;
    logic [1:0] s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [1:0] s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
    logic [1:0][DW-1:0] s_wdata, s_rdata;
    logic [1:0][DW/8-1:0] s_wstrb;
    logic [IW-1:0] m00_axi_awid, m00_axi_wid, m00_axi_bid, m00_axi_arid, m00_axi_rid;
    logic [AW-1:0] m00_axi_awaddr, m00_axi_araddr;
    logic [LW-1:0] m00_axi_awlen, m00_axi_arlen;
    logic [2:0] m00_axi_awsize, m00_axi_arsize, m00_axi_awprot, m00_axi_arprot;
    logic [1:0] m00_axi_awburst, m00_axi_arburst, m00_axi_awlock, m00_axi_arlock;
    logic [3:0] m00_axi_awcache, m00_axi_arcache, m00_axi_awqos, m00_axi_arqos;
    logic m00_axi_awvalid, m00_axi_awready, m00_axi_wlast, m00_axi_wvalid, m00_axi_wready;
    logic m00_axi_bvalid, m00_axi_bready, m00_axi_arvalid, m00_axi_arready;
    logic m00_axi_rlast, m00_axi_rvalid, m00_axi_rready;
    logic [DW-1:0] m00_axi_wdata, m00_axi_rdata;
    logic [DW/8-1:0] m00_axi_wstrb;
    logic [1:0] m00_axi_bresp, m00_axi_rresp;
    logic [1:0][31:0] grant_cnt_o;
    int n_chk = 0, n_err = 0;
    int exp_cnt [2];

    always #5 aclk = ~aclk;

    zynq_axi_m_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .ID_W(IW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
        .s_wready(s_wready), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
        .s_rready(s_rready),
        .m00_axi_awid(m00_axi_awid), .m00_axi_awaddr(m00_axi_awaddr), .m00_axi_awlen(m00_axi_awlen),
        .m00_axi_awsize(m00_axi_awsize), .m00_axi_awburst(m00_axi_awburst),
        .m00_axi_awlock(m00_axi_awlock), .m00_axi_awcache(m00_axi_awcache),
        .m00_axi_awprot(m00_axi_awprot), .m00_axi_awqos(m00_axi_awqos),
        .m00_axi_awvalid(m00_axi_awvalid), .m00_axi_awready(m00_axi_awready),
        .m00_axi_wid(m00_axi_wid), .m00_axi_wdata(m00_axi_wdata), .m00_axi_wstrb(m00_axi_wstrb),
        .m00_axi_wlast(m00_axi_wlast), .m00_axi_wvalid(m00_axi_wvalid), .m00_axi_wready(m00_axi_wready),
        .m00_axi_bid(m00_axi_bid), .m00_axi_bresp(m00_axi_bresp), .m00_axi_bvalid(m00_axi_bvalid),
        .m00_axi_bready(m00_axi_bready),
        .m00_axi_arid(m00_axi_arid), .m00_axi_araddr(m00_axi_araddr), .m00_axi_arlen(m00_axi_arlen),
        .m00_axi_arsize(m00_axi_arsize), .m00_axi_arburst(m00_axi_arburst),
        .m00_axi_arlock(m00_axi_arlock), .m00_axi_arcache(m00_axi_arcache),
        .m00_axi_arprot(m00_axi_arprot), .m00_axi_arqos(m00_axi_arqos),
        .m00_axi_arvalid(m00_axi_arvalid), .m00_axi_arready(m00_axi_arready),
        .m00_axi_rid(m00_axi_rid), .m00_axi_rdata(m00_axi_rdata), .m00_axi_rresp(m00_axi_rresp),
        .m00_axi_rlast(m00_axi_rlast), .m00_axi_rvalid(m00_axi_rvalid), .m00_axi_rready(m00_axi_rready),
        .grant_cnt_o(grant_cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cnt_check(input string tag);
        check(tag, 64'(grant_cnt_o), PERF ? {32'(exp_cnt[1]), 32'(exp_cnt[0])} : 64'd0);
    endtask

    // Tasks start and end just after a falling edge with the FSM idle.
    task automatic write_burst(input int r, input logic [31:0] addr, input int len,
                               input logic [31:0] base, input logic [1:0] bresp);
        s_awaddr[r] = addr; s_awlen[r] = LW'(len); s_awsize[r] = 3'd2;
        s_awburst[r] = 2'b01; s_awvalid[r] = 1'b1;
        #1 check("aw_idle", 64'(m00_axi_awvalid), 64'd0);
        @(negedge aclk);
        m00_axi_awready = 1'b1;
        #1 check("awvalid", 64'(m00_axi_awvalid), 64'd1);
        check("awaddr", 64'(m00_axi_awaddr), 64'(addr));
        check("awlen", 64'(m00_axi_awlen), 64'(len));
        check("awid", 64'(m00_axi_awid), 64'(r));
        check("awcache", 64'(m00_axi_awcache), 64'h3);
        check("awready", 64'(s_awready), 64'(1 << r));
        check("wready_addr", 64'(s_wready), 64'd0);
        @(negedge aclk);
        s_awvalid[r] = 1'b0; m00_axi_awready = 1'b0; m00_axi_wready = 1'b1;
        for (int k = 0; k <= len; k++) begin
            s_wdata[r] = base + 32'(k); s_wstrb[r] = 4'hf;
            s_wlast[r] = (k == len); s_wvalid[r] = 1'b1;
            #1 check("wdata", 64'(m00_axi_wdata), 64'(base + 32'(k)));
            check("wid", 64'(m00_axi_wid), 64'(r));
            check("wready", 64'(s_wready), 64'(1 << r));
            @(negedge aclk);
        end
        s_wvalid[r] = 1'b0; s_wlast[r] = 1'b0; m00_axi_wready = 1'b0;
        m00_axi_bvalid = 1'b1; m00_axi_bresp = bresp; m00_axi_bid = IW'(r); s_bready[r] = 1'b1;
        #1 check("bvalid", 64'(s_bvalid), 64'(1 << r));
        check("bresp", 64'(s_bresp[r]), 64'(bresp));
        check("bready", 64'(m00_axi_bready), 64'd1);
        @(negedge aclk);
        m00_axi_bvalid = 1'b0; exp_cnt[r]++;
        #1 check("w_back_idle", 64'(m00_axi_bready), 64'd0);
        s_bready[r] = 1'b0;
    endtask

    task automatic read_burst(input int r, input logic [31:0] addr, input int len,
                              input logic [31:0] base);
        s_araddr[r] = addr; s_arlen[r] = LW'(len); s_arsize[r] = 3'd2;
        s_arburst[r] = 2'b01; s_arvalid[r] = 1'b1;
        #1 check("ar_idle", 64'(m00_axi_arvalid), 64'd0);
        @(negedge aclk);
        m00_axi_arready = 1'b1;
        #1 check("arvalid", 64'(m00_axi_arvalid), 64'd1);
        check("araddr", 64'(m00_axi_araddr), 64'(addr));
        check("arid", 64'(m00_axi_arid), 64'(r));
        check("arready", 64'(s_arready), 64'(1 << r));
        @(negedge aclk);
        s_arvalid[r] = 1'b0; m00_axi_arready = 1'b0; s_rready[r] = 1'b1;
        for (int k = 0; k <= len; k++) begin
            m00_axi_rvalid = 1'b1; m00_axi_rdata = base + 32'(k);
            m00_axi_rlast = (k == len); m00_axi_rresp = 2'b00; m00_axi_rid = IW'(r);
            #1 check("rvalid", 64'(s_rvalid), 64'(1 << r));
            check("rdata", 64'(s_rdata[r]), 64'(base + 32'(k)));
            check("rdata_other", 64'(s_rdata[1-r]), 64'd0);
            check("rready", 64'(m00_axi_rready), 64'd1);
            @(negedge aclk);
        end
        m00_axi_rvalid = 1'b0; m00_axi_rlast = 1'b0; exp_cnt[r]++;
        #1 check("r_back_idle", 64'(m00_axi_rready), 64'd0);
        s_rready[r] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        {s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid} = '0;
        {s_wdata, s_wstrb, s_wlast, s_wvalid, s_bready} = '0;
        {s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, s_rready} = '0;
        {m00_axi_awready, m00_axi_wready, m00_axi_bid, m00_axi_bresp, m00_axi_bvalid} = '0;
        {m00_axi_arready, m00_axi_rid, m00_axi_rdata, m00_axi_rresp, m00_axi_rlast, m00_axi_rvalid} = '0;
        exp_cnt[0] = 0; exp_cnt[1] = 0;
        repeat (2) @(negedge aclk);
        #1 check("rst_awvalid", 64'(m00_axi_awvalid), 64'd0);
        check("rst_arvalid", 64'(m00_axi_arvalid), 64'd0);
        check("rst_s_valids", 64'({s_awready, s_wready, s_bvalid, s_arready, s_rvalid}), 64'd0);
        check("rst_cnt", 64'(grant_cnt_o), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        // Simultaneous AW requests: req0 first, then req1
        s_awvalid = 2'b11; s_awaddr[1] = 32'h200; s_awlen[1] = 4'd3;
        write_burst(0, 32'h100, 3, 32'hA000, 2'b00);
        write_burst(1, 32'h200, 3, 32'hB000, 2'b00);
        cnt_check("cnt_rr");
        // Read on req1 in parallel with a write on req0
        fork
            write_burst(0, 32'h300, 1, 32'hC000, 2'b00);
            read_burst(1, 32'h1000, 0, 32'hDEADBEEF);
        join
        cnt_check("cnt_parallel");
        write_burst(1, 32'h400, 0, 32'hD000, 2'b10);
        // W presented three cycles ahead of AW must wait
        s_wvalid[0] = 1'b1; s_wdata[0] = 32'hE000; s_wstrb[0] = 4'hf; m00_axi_wready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1 check("early_wready", 64'(s_wready), 64'd0);
            check("early_m_wvalid", 64'(m00_axi_wvalid), 64'd0);
            @(negedge aclk);
        end
        write_burst(0, 32'h500, 1, 32'hE000, 2'b00);
        // B and R-last for the same requester on the same edge
        fork
            write_burst(0, 32'h600, 0, 32'hF000, 2'b00);
            read_burst(0, 32'h2000, 1, 32'h5000);
        join
        cnt_check("cnt_dual");
        // Reset during beat 2 of a 4-beat read
        s_araddr[0] = 32'h3000; s_arlen[0] = 4'd3; s_arvalid[0] = 1'b1;
        @(negedge aclk);
        m00_axi_arready = 1'b1;
        @(negedge aclk);
        s_arvalid[0] = 1'b0; m00_axi_arready = 1'b0; s_rready[0] = 1'b1;
        m00_axi_rvalid = 1'b1; m00_axi_rdata = 32'h7000;
        @(negedge aclk);
        m00_axi_rdata = 32'h7001;
        #1 check("mid_rvalid", 64'(s_rvalid), 64'd1);
        aresetn = 1'b0;
        exp_cnt[0] = 0; exp_cnt[1] = 0;
        #1 check("arst_rvalid", 64'(s_rvalid), 64'd0);
        check("arst_rready", 64'(m00_axi_rready), 64'd0);
        check("arst_mvalids", 64'({m00_axi_awvalid, m00_axi_wvalid, m00_axi_arvalid}), 64'd0);
        check("arst_cnt", 64'(grant_cnt_o), 64'd0);
        @(negedge aclk);
        m00_axi_rvalid = 1'b0; s_rready[0] = 1'b0; aresetn = 1'b1;
        read_burst(0, 32'h3000, 3, 32'h8000);
        cnt_check("cnt_after_rst");
        // Counter run: 5 writes on req0, 3 reads on req1
        aresetn = 1'b0;
        exp_cnt[0] = 0; exp_cnt[1] = 0;
        @(negedge aclk);
        aresetn = 1'b1;
        for (int n = 0; n < 5; n++) write_burst(0, 32'h4000 + 32'(n), 0, 32'h100 * 32'(n), 2'b00);
        for (int n = 0; n < 3; n++) read_burst(1, 32'h5000 + 32'(n), 0, 32'h900 + 32'(n));
        cnt_check("cnt_5w_3r");
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
